// File: rtl/demux5_pkg.sv
// rtl/demux5_pkg.sv - shared constants and types for the 1:5 demux collector
// Optional feature macro: DEMUX5_AUTOSEL_EN
package demux5_pkg;

    localparam int NSLOTS = 5;
    localparam int SEL_W  = 3;

    localparam logic [NSLOTS-1:0] FULL_MASK = 5'b11111;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

endpackage

// File: rtl/demux5_collect_if.sv
// rtl/demux5_collect_if.sv - beat input / word output handshake bundle
interface demux5_collect_if #(
    parameter int W = 1
);
    import demux5_pkg::*;

    logic [W-1:0]        in_data;
    logic [SEL_W-1:0]    s;
    logic                in_valid;
    logic                in_ready;
    logic [NSLOTS*W-1:0] out_data;
    logic                out_valid;
    logic                out_ready;
    logic                err;

    // Producer of beats and consumer of words
    modport master (
        output in_data,
        output s,
        output in_valid,
        input  in_ready,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  err
    );

    // The collector itself
    modport slave (
        input  in_data,
        input  s,
        input  in_valid,
        output in_ready,
        output out_data,
        output out_valid,
        input  out_ready,
        output err
    );

endinterface

// File: rtl/demux5_dec.sv
// rtl/demux5_dec.sv - 3-to-5 one-hot slot write-enable decoder
module demux5_dec
    import demux5_pkg::*;
(
    input  logic [SEL_W-1:0]  s,
    input  logic              en,
    output logic [NSLOTS-1:0] we,
    output logic              oor
);

    // One-hot enable for selects 0..4; selects 5..7 enable nothing and flag oor
    always_comb begin
        we  = '0;
        oor = 1'b0;
        if (en) begin
            case (s)
                3'd0:    we = 5'b00001;
                3'd1:    we = 5'b00010;
                3'd2:    we = 5'b00100;
                3'd3:    we = 5'b01000;
                3'd4:    we = 5'b10000;
                default: oor = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/demux5_collect.sv
// rtl/demux5_collect.sv - 1:5 demux collector assembling five beats into one word
// Optional feature macro: DEMUX5_AUTOSEL_EN (internal slot pointer replaces s)
module demux5_collect
    import demux5_pkg::*;
#(
    parameter int W = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    demux5_collect_if.slave  bus
);

    state_t              state_q;
    state_t              state_d;
    logic [NSLOTS-1:0]   mask_q;
    logic [NSLOTS-1:0]   mask_next;
    logic [NSLOTS*W-1:0] slots_q;
    logic [NSLOTS-1:0]   we;
    logic [SEL_W-1:0]    sel;
    logic                oor;
    logic                accept;
    logic                go_full;
    logic                handshake;

    // Beats are only taken while filling; state_q is used directly so that
    // accept never depends on the in_ready output
    assign accept    = bus.in_valid && (state_q == FILL);
    assign handshake = (state_q == FULL) && bus.out_ready;
    assign mask_next = mask_q | we;
    assign go_full   = accept && (mask_next == FULL_MASK);

`ifdef DEMUX5_AUTOSEL_EN
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W:0]   unused_autosel;

    assign sel            = ptr_q;
    assign unused_autosel = {oor, bus.s};

    // Slot pointer walks 0..4 on each accepted beat and wraps after slot 4
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (clear) begin
            ptr_q <= '0;
        end else if (accept) begin
            ptr_q <= (ptr_q == 3'd4) ? 3'd0 : ptr_q + 3'd1;
        end
    end

    assign bus.err = 1'b0;
`else
    logic err_q;

    assign sel = bus.s;

    // Sticky flag for an accepted out-of-range select; only clear removes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (clear) begin
            err_q <= 1'b0;
        end else if (oor) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`endif

    demux5_dec u_dec (
        .s   (sel),
        .en  (accept),
        .we  (we),
        .oor (oor)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; clear wins over fill and handshake
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            FILL: begin
                bus.in_ready = 1'b1;
                if (go_full) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        if (clear) begin
            state_d = FILL;
        end
    end

    // Written-slot mask; emptied when the word is handed off or flushed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else if (clear || handshake) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_next;
        end
    end

    // Slot registers; last write to a slot wins, handoff leaves contents intact
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slots_q <= '0;
        end else if (clear) begin
            slots_q <= '0;
        end else begin
            for (int i = 0; i < NSLOTS; i++) begin
                if (we[i]) begin
                    slots_q[i*W +: W] <= bus.in_data;
                end
            end
        end
    end

    assign bus.out_data = slots_q;

endmodule

// File: tb/tb_demux5_collect.sv
// tb/tb_demux5_collect.sv - directed and random checks of demux5_collect against a slot-array model
module tb_demux5_collect;
    import demux5_pkg::*;

`ifdef DEMUX5_AUTOSEL_EN
    localparam int W = 4;
`else
    localparam int W = 1;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic clear;

    always #5 clk = ~clk;

    demux5_collect_if #(.W(W)) bus();

    demux5_collect #(.W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .bus     (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] slot_m [NSLOTS];
    logic [4:0]   mask_m;
    bit           err_m;
    bit           full_m;
    int           ptr_m;

    function automatic logic [31:0] word_m();
        logic [31:0] w = '0;
        for (int i = 0; i < NSLOTS; i++) w[i*W +: W] = slot_m[i];
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NSLOTS; i++) slot_m[i] = '0;
        mask_m = '0;
        err_m  = 1'b0;
        full_m = 1'b0;
        ptr_m  = 0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/out_valid"}, 32'(bus.out_valid), 32'(full_m));
        check({tag, "/in_ready"},  32'(bus.in_ready),  32'(!full_m));
        check({tag, "/err"},       32'(bus.err),       32'(err_m));
        check({tag, "/out_data"},  32'(bus.out_data),  word_m());
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, check
    task automatic cycle(input bit v, input int sel, input logic [3:0] d,
                         input bit ordy, input bit clr, input string tag);
        int esel;
        bus.in_valid  = v;
        bus.s         = sel[2:0];
        bus.in_data   = d[W-1:0];
        bus.out_ready = ordy;
        clear         = clr;
        @(posedge clk);
        if (clr) begin
            model_reset();
        end else if (full_m) begin
            if (ordy) begin
                full_m = 1'b0;
                mask_m = '0;
            end
        end else if (v) begin
`ifdef DEMUX5_AUTOSEL_EN
            esel  = ptr_m;
            ptr_m = (ptr_m + 1) % NSLOTS;
`else
            esel  = sel % 8;
`endif
            if (esel < NSLOTS) begin
                slot_m[esel] = d[W-1:0];
                mask_m[esel] = 1'b1;
            end else begin
                err_m = 1'b1;
            end
            if (mask_m == 5'b11111) full_m = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    logic [3:0] dv [5];

    initial begin
        reset_n       = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.s         = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;

        // Basic word with consumer stalled, then held beat, then handoff
        dv = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
        for (int i = 0; i < 5; i++) cycle(1, i, dv[i], 0, 0, "fill");
`ifndef DEMUX5_AUTOSEL_EN
        check("word01101", 32'(bus.out_data), 32'h0d);
`endif
        for (int i = 0; i < 4; i++) cycle(1, 0, 4'd0, 0, 0, "hold");
        cycle(1, 0, 4'd0, 1, 0, "handshake");
        cycle(0, 0, 4'd0, 0, 0, "idle");

        // Overwrite of slot 1 before completion
        cycle(1, 0, 4'd1, 0, 0, "ow0");
        cycle(1, 1, 4'd0, 0, 0, "ow1a");
        cycle(1, 1, 4'd1, 0, 0, "ow1b");
        cycle(1, 2, 4'd0, 0, 0, "ow2");
        cycle(1, 3, 4'd1, 0, 0, "ow3");
        cycle(1, 4, 4'd1, 0, 0, "ow4");
`ifndef DEMUX5_AUTOSEL_EN
        check("word11011", 32'(bus.out_data), 32'h1b);
`endif
        cycle(0, 0, 4'd0, 1, 0, "ow_hs");

        // Out-of-range select, completion with err held, then clear with a dropped beat
        cycle(1, 6, 4'd1, 0, 0, "oor");
`ifndef DEMUX5_AUTOSEL_EN
        check("err_set", 32'(bus.err), 32'd1);
`endif
        for (int i = 0; i < 5; i++) cycle(1, i, 4'(i + 3), 0, 0, "oor_fill");
        cycle(1, 0, 4'd1, 0, 1, "clear");
        cycle(0, 0, 4'd0, 0, 0, "post_clear");

        // Asynchronous reset mid-word
        for (int i = 0; i < 3; i++) cycle(1, i, 4'd1, 0, 0, "pre_rst");
        bus.in_valid = 1'b0;
        #1 reset_n = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #1 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1, i, 4'(i + 1), 0, 0, "post_rst");
        cycle(0, 0, 4'd0, 1, 0, "post_rst_hs");

`ifdef DEMUX5_AUTOSEL_EN
        // Pointer selects slots regardless of s
        dv = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE};
        for (int i = 0; i < 5; i++) cycle(1, int'($urandom % 8), dv[i], 0, 0, "auto");
        check("word_edcba", 32'(bus.out_data), 32'hEDCBA);
        cycle(0, 0, 4'd0, 1, 0, "auto_hs");
        cycle(1, int'($urandom % 8), 4'hF, 0, 0, "auto_wrap");
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, int'($urandom % 8), 4'($urandom),
                  ($urandom % 2) != 0, ($urandom % 25) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/demux5_collect.md
Name: demux5_collect

Overview:
- Sequential 1:5 demultiplexing collector; the write-side counterpart of the 5:1 select mux in the Robertson multiplier datapath.
- Accepts beats of W-bit data, each tagged with a 3-bit slot select `s`, and steers each beat into one of five slot registers.
- Once all five slots are written, it presents the assembled 5*W-bit word on a valid/ready output.
- Used to gather multiplier operand/partial fields before they are handed back to the mux-driven datapath.

Parameters:
W, 1, data width per slot (bits)

Ports:
clk        input   1      rising-edge clock
reset_n    input   1      asynchronous active-low reset
clear      input   1      synchronous flush; discards partial/held word and clears err
in_data    input   W      beat data
s          input   3      slot select; 0..4 valid, 5..7 out of range
in_valid   input   1      beat offered
in_ready   output  1      collector can accept beat
out_data   output  5*W    assembled word; slot i at bits [i*W +: W]
out_valid  output  1      word complete and held
out_ready  input   1      consumer takes word
err        output  1      sticky: an out-of-range select was accepted

Behaviour:
- Interface: one clock `clk`; reset `reset_n` is asynchronous and active-low.
- Reset (`reset_n` low, asynchronous):
  - state=FILL; slot mask=0; all slot registers=0.
  - out_valid=0, err=0, in_ready=1 after release, out_data=0.
- States: FILL, FULL.
- FILL:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid&&in_ready.
  - Accept with s in 0..4: slot[s]<=in_data and mask[s]<=1 at the next edge.
  - Rewriting an already-set slot overwrites it; last write wins, mask unchanged.
  - Accept with s in 5..7: no slot written, mask unchanged, err<=1 (sticky). This mirrors the mux, which outputs 0 for those selects.
  - If the accept makes mask==5'b11111, the next state is FULL.
- FULL:
  - in_ready=0, out_valid=1.
  - out_data is stable until the handshake.
  - On out_valid&&out_ready: state<=FILL and mask<=0. Slot registers keep their values; they are overwritten by later beats.
  - out_valid falls in the cycle after the handshake.
- Latency: the word is valid in the cycle after the accept of the 5th distinct slot.
- Throughput: no bypass; in_ready=0 throughout FULL, so a minimum of 6 cycles per word with a consumer that is always ready.
- out_data is driven from the slot registers at all times, but is meaningful only while out_valid=1.
- clear (synchronous):
  - Has highest priority over accept and handshake in the same cycle.
  - state<=FILL, mask<=0, slots<=0, err<=0.
  - A beat offered in the clear cycle is dropped. in_ready is still 1 in FILL during that cycle, so the bench must not count that beat.
- reset_n asserted mid-word: immediate return to reset values, and the partial word is lost.
- in_valid while in FULL: not accepted; the source must hold the beat.

Optional Feature:
DEMUX5_AUTOSEL_EN
- Defined:
  - `s` is ignored.
  - An internal 3-bit pointer (reset 0) selects the slot and increments on each accept.
  - After the accept to slot 4 the pointer wraps to 0 and the block enters FULL.
  - clear resets the pointer to 0.
  - err is tied to 0.
- Undefined: behaviour as above, with explicit `s`; no pointer register exists.

Decomposition:
- Package demux5_pkg:
  - NSLOTS=5, SEL_W=3.
  - typedef enum logic {FILL, FULL} state_t.
  - localparam FULL_MASK=5'b11111.
- Sub-module demux5_dec: purely combinational 3-to-5 one-hot write-enable decoder.
  - Input: s, en. Output: we[4:0].
  - we=0 for s in 5..7 or en=0.
  - Also outputs oor = en&&(s>4).
- demux5_collect instantiates demux5_dec.

Test Plan:
- Reset with W=1, then beats (s,d) = (0,1),(1,0),(2,1),(3,1),(4,0) on consecutive cycles -> out_valid=1 the cycle after the 5th beat, out_data=5'b01101, in_ready=0, err=0.
- Same 5 beats with out_ready held 0 for 4 cycles, in_valid held 1 with s=0 -> out_data stable, no accept. Then raise out_ready -> out_valid=0 the next cycle and in_ready=1.
- Beats s=0,1,1(d=1 overwrite),2,3 -> still FILL, out_valid=0. Then s=4 -> FULL with slot1 holding the last written value.
- Beat with s=6 -> err=1, mask unchanged. Complete the word -> out_valid=1, err still 1. Pulse clear -> err=0, FILL, out_data=0.
- Assert reset_n low mid-clock after 3 beats -> out_valid=0 and out_data=0 immediately. After release, 5 fresh beats are required for a word.
- With DEMUX5_AUTOSEL_EN and W=4, send beats A,B,C,D,E with random `s` -> out_data=0xEDCBA, err=0; pointer restarts at slot 0 for the next word.
